// File: rtl/ir_controller_pkg.sv
// ir_controller_pkg: shared types for the external interrupt front-end.
// Holds the 2-bit FSM state encoding used by ir_controller.
package ir_controller_pkg;

  typedef enum logic [1:0] {
    IR_IDLE    = 2'd0,
    IR_PENDING = 2'd1,
    IR_SERVICE = 2'd2
  } ir_state_e;

endpackage

// File: rtl/ir_controller_if.sv
// ir_controller_if: CP0-facing handshake of the interrupt front-end.
//   ir_en          CP0 -> ctrl  CP0 will accept an interrupt
//   ir_ack         CP0 -> ctrl  one-cycle pulse, interrupt taken
//   eret           CP0 -> ctrl  one-cycle pulse, handler returned
//   ir_req         ctrl -> CP0  request into CP0 ir_in
//   ir_pending     ctrl -> CP0  request latched, not yet acknowledged
//   ir_in_service  ctrl -> CP0  handler running (between ack and ERET)
//   ir_lost_cnt    ctrl -> CP0  saturating count of dropped rising edges
// master = CP0 side, slave = ir_controller side.
interface ir_controller_if #(
  parameter int unsigned LOST_W = 8
);
  logic              ir_en;
  logic              ir_ack;
  logic              eret;
  logic              ir_req;
  logic              ir_pending;
  logic              ir_in_service;
  logic [LOST_W-1:0] ir_lost_cnt;

  modport master (
    output ir_en, ir_ack, eret,
    input  ir_req, ir_pending, ir_in_service, ir_lost_cnt
  );

  modport slave (
    input  ir_en, ir_ack, eret,
    output ir_req, ir_pending, ir_in_service, ir_lost_cnt
  );
endinterface

// File: rtl/ir_debounce.sv
// ir_debounce: two-flop synchronizer for the raw interrupt line, plus an
// optional debounce filter selected by the IR_DEBOUNCE_EN macro.
//   i_clk     main clock
//   i_rst     asynchronous active-high reset
//   i_btn_in  raw line, asynchronous to i_clk
//   o_lvl     filtered level
// With IR_DEBOUNCE_EN, o_lvl only follows the synchronized line after it has
// differed from o_lvl for DEBOUNCE_CYCLES consecutive cycles. Without it,
// o_lvl is the synchronizer output itself.
module ir_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_in,
  output logic o_lvl
);

  if (DEBOUNCE_CYCLES == 0) begin : g_chk_cycles
    $error("ir_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if ((DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_chk_width
    $error("ir_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IR_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_lvl;
  logic [CNT_W-1:0] r_cnt;

  // Counter measures how long the line has disagreed with the filtered level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_lvl <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_lvl = r_lvl;
`else
  // No filter stage: the synchronizer output is the level, so a request
  // lands two edges after the line is first sampled.
  assign o_lvl = r_sync2;
`endif

endmodule

// File: rtl/ir_controller.sv
// ir_controller: turns a raw push-button line into a single-shot interrupt
// request for CP0, held until acknowledged and blocked until ERET.
//   i_clk     main clock
//   i_rst     asynchronous active-high reset
//   i_btn_in  raw external interrupt line
//   io_cp0    CP0 handshake (slave modport): ir_en, ir_ack, eret in;
//             ir_req, ir_pending, ir_in_service, ir_lost_cnt out
// Macro IR_DEBOUNCE_EN enables the debounce counter inside ir_debounce.
module ir_controller
  import ir_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned LOST_W          = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_btn_in,
  ir_controller_if.slave  io_cp0
);

  logic              w_lvl;
  logic              r_lvl_q;
  logic              w_rise;
  logic              w_lost_inc;
  ir_state_e         r_state;
  ir_state_e         w_state_next;
  logic [LOST_W-1:0] r_lost_cnt;

  ir_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_btn_in (i_btn_in),
    .o_lvl    (w_lvl)
  );

  assign w_rise = w_lvl & ~r_lvl_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lvl_q    <= 1'b0;
      r_state    <= IR_IDLE;
      r_lost_cnt <= '0;
    end else begin
      r_lvl_q <= w_lvl;
      r_state <= w_state_next;
      if (w_lost_inc && (r_lost_cnt != '1)) begin
        r_lost_cnt <= r_lost_cnt + LOST_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lost_inc   = 1'b0;
    case (r_state)
      IR_IDLE: begin
        if (w_rise) w_state_next = IR_PENDING;
      end
      IR_PENDING: begin
        // A new edge while one is already latched is dropped, even if the
        // latched one is being acknowledged this cycle.
        w_lost_inc = w_rise;
        if (io_cp0.ir_ack) w_state_next = IR_SERVICE;
      end
      IR_SERVICE: begin
        // An edge coinciding with ERET becomes the next request, not a loss.
        if (io_cp0.eret) begin
          w_state_next = w_rise ? IR_PENDING : IR_IDLE;
        end else begin
          w_lost_inc = w_rise;
        end
      end
      default: w_state_next = IR_IDLE;
    endcase
  end

  assign io_cp0.ir_req        = (r_state == IR_PENDING) & io_cp0.ir_en;
  assign io_cp0.ir_pending    = (r_state == IR_PENDING);
  assign io_cp0.ir_in_service = (r_state == IR_SERVICE);
  assign io_cp0.ir_lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_ir_controller.sv
// tb_ir_controller: directed stimulus with a scoreboard queue. Stimulus pushes
// the expected {ir_req, ir_pending, ir_in_service, ir_lost_cnt} tagged with
// the clock edge after which it must hold; a monitor pops and compares.
module tb_ir_controller;

  localparam int unsigned DEB    = 4;
  localparam int unsigned LOST_W = 8;
`ifdef IR_DEBOUNCE_EN
  localparam int LAT         = 3 + DEB;  // edges from btn raise to ir_pending
  localparam bit GLITCH_SEEN = 1'b0;
`else
  localparam int LAT         = 3;
  localparam bit GLITCH_SEEN = 1'b1;
`endif

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [7:0] el;

  ir_controller_if #(.LOST_W(LOST_W)) cp0 ();

  ir_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (16),
    .LOST_W          (LOST_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_in (btn),
    .io_cp0   (cp0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] cur();
    return {cp0.ir_req, cp0.ir_pending, cp0.ir_in_service, cp0.ir_lost_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (req,pend,svc,lost)", name, act, exp);
    end
  endtask

  task automatic expect_at(input int dly, input string name, input bit req, input bit pend,
                           input bit svc, input logic [7:0] lost);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = name;
    e.exp  = {req, pend, svc, lost};
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    cp0.ir_ack = 1'b1;
    step(1);
    cp0.ir_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    cp0.eret = 1'b1;
    step(1);
    cp0.eret = 1'b0;
  endtask

  // Monitor: sample just after each rising edge.
  always @(posedge clk) begin
    #2;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for edge %0d not checked (now %0d)", mon_e.name,
                 mon_e.cyc, cyc);
      end else begin
        chk(mon_e.name, 32'(cur()), 32'(mon_e.exp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    cp0.ir_en  = 1'b1;
    cp0.ir_ack = 1'b0;
    cp0.eret   = 1'b0;
    #1 rst = 1'b1;
    step(2);
    chk("reset_hold", 32'(cur()), 32'({3'b000, 8'd0}));
    rst = 1'b0;
    expect_at(1, "reset_idle", 0, 0, 0, 8'd0);
    step(3);

    // Basic request / ack / eret.
    btn = 1'b1;
    expect_at(LAT - 1, "basic_early", 0, 0, 0, 8'd0);
    expect_at(LAT, "basic_req", 1, 1, 0, 8'd0);
    step(10);
    btn = 1'b0;
    step(10);
    expect_at(1, "basic_ack", 0, 0, 1, 8'd0);
    pulse_ack();
    step(5);
    expect_at(1, "basic_eret", 0, 0, 0, 8'd0);
    pulse_eret();
    step(3);

    // 3-cycle glitch; ack/eret afterwards are ignored if it was filtered.
    btn = 1'b1;
    expect_at(LAT, "glitch_pend", GLITCH_SEEN, GLITCH_SEEN, 0, 8'd0);
    expect_at(LAT + 4, "glitch_late", GLITCH_SEEN, GLITCH_SEEN, 0, 8'd0);
    step(3);
    btn = 1'b0;
    step(10);
    expect_at(1, "glitch_ack", 0, 0, GLITCH_SEEN, 8'd0);
    pulse_ack();
    step(2);
    expect_at(1, "glitch_eret", 0, 0, 0, 8'd0);
    pulse_eret();
    step(3);

    // 4-cycle pulse is the shortest that passes the filter.
    btn = 1'b1;
    expect_at(LAT, "pulse4_pend", 1, 1, 0, 8'd0);
    step(4);
    btn = 1'b0;
    step(10);
    expect_at(1, "pulse4_ack", 0, 0, 1, 8'd0);
    pulse_ack();
    step(2);
    expect_at(1, "pulse4_eret", 0, 0, 0, 8'd0);
    pulse_eret();
    step(3);

    // Masking by ir_en.
    cp0.ir_en = 1'b0;
    btn = 1'b1;
    expect_at(LAT, "mask_pend", 0, 1, 0, 8'd0);
    step(10);
    btn = 1'b0;
    step(10);
    cp0.ir_en = 1'b1;
    #1;
    chk("mask_unmask", 32'(cur()), 32'({3'b110, 8'd0}));
    expect_at(1, "mask_hold", 1, 1, 0, 8'd0);
    step(2);
    expect_at(1, "mask_ack", 0, 0, 1, 8'd0);
    pulse_ack();
    step(10);

    // rise coincident with eret: straight to PENDING, not lost.
    btn = 1'b1;
    expect_at(LAT - 1, "pre_rise_eret", 0, 0, 1, 8'd0);
    expect_at(LAT, "rise_eret", 1, 1, 0, 8'd0);
    step(LAT - 1);
    pulse_eret();
    step(6);
    btn = 1'b0;
    step(10);

    // rise coincident with ack: SERVICE, counted as lost.
    btn = 1'b1;
    expect_at(LAT - 1, "pre_rise_ack", 1, 1, 0, 8'd0);
    expect_at(LAT, "rise_ack", 0, 0, 1, 8'd1);
    step(LAT - 1);
    pulse_ack();
    step(6);
    btn = 1'b0;
    step(10);

    // Four more dropped presses in SERVICE -> lost = 5.
    for (int i = 0; i < 4; i++) begin
      btn = 1'b1;
      expect_at(LAT, "svc_lost", 0, 0, 1, 8'(2 + i));
      step(6);
      btn = 1'b0;
      step(8);
    end

    // Asynchronous reset mid-cycle with the line held high through release.
    #2;
    btn = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(cur()), 32'({3'b000, 8'd0}));
    step(2);
    rst = 1'b0;
    expect_at(LAT - 1, "rst_rel_early", 0, 0, 0, 8'd0);
    expect_at(LAT, "rst_rel_req", 1, 1, 0, 8'd0);
    expect_at(LAT + 15, "rst_rel_once", 1, 1, 0, 8'd0);
    step(LAT + 20);
    expect_at(1, "rst_rel_ack", 0, 0, 1, 8'd0);
    pulse_ack();
    btn = 1'b0;
    step(10);

    // 300 presses in SERVICE: counter saturates at 255, state unchanged.
    for (int i = 0; i < 300; i++) begin
      el = (i >= 254) ? 8'd255 : 8'(i + 1);
      btn = 1'b1;
      expect_at(LAT, "sat_lost", 0, 0, 1, el);
      step(6);
      btn = 1'b0;
      step(8);
    end
    expect_at(1, "sat_eret", 0, 0, 0, 8'd255);
    pulse_eret();
    step(5);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_controller.md
# ir_controller

External interrupt front-end for the MIPS 5-stage core. Takes a raw asynchronous push-button line and delivers a clean, single-shot interrupt request to the CP0 co-processor's `ir_in`. It holds the request until CP0 acknowledges it and blocks new requests until the handler returns via ERET. It sits upstream of CP0 at the `mips_core` top level, alongside the core's `clk`/`rst`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before the filtered level changes; must be ≥ 1.
- `CNT_W`, default 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `LOST_W`, default 8: width of the dropped-event counter.
- `clk`  in  1  main clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `btn_in`  in  1  raw external interrupt line, asynchronous to `clk`.
- `ir_en`  in  1  from CP0; high when CP0 will accept an interrupt.
- `ir_ack`  in  1  from CP0; one-cycle pulse when the interrupt is taken (forced jump).
- `eret`  in  1  from CP0; one-cycle pulse when ERET executes.
- `ir_req`  out  1  to CP0 `ir_in`.
- `ir_pending`  out  1  a request is latched and not yet acknowledged.
- `ir_in_service`  out  1  handler is running, between ack and ERET.
- `ir_lost_cnt`  out  LOST_W  saturating count of rising edges dropped.

## Operation
- **Synchronizer.** Two flops, `sync1` then `sync2`.
- **Filtered level `lvl`.** Passes through the debounce stage (see Configuration).
- **Edge detect.** `rise = lvl & ~lvl_q`, where `lvl_q` is `lvl` registered.
- **FSM states.** IDLE, PENDING, SERVICE.
  - IDLE: on `rise`, go to PENDING.
  - PENDING: on `ir_ack`, go to SERVICE.
  - SERVICE: on `eret`, go to IDLE.
- **Outputs (combinational from registered state).**
  - `ir_req = (state==PENDING) & ir_en`.
  - `ir_pending = (state==PENDING)`.
  - `ir_in_service = (state==SERVICE)`.
- **Lost events.** `rise` in PENDING or SERVICE increments `ir_lost_cnt` by 1, saturating at all-ones. There is no wrap.
- **Simultaneous events.**
  - SERVICE with `rise` and `eret` in the same cycle: go directly to PENDING. Not counted as lost.
  - PENDING with `rise` and `ir_ack` in the same cycle: go to SERVICE. Counted as lost.
- **Ignored inputs.**
  - `ir_ack` outside PENDING has no effect.
  - `eret` outside SERVICE has no effect.
  - `ir_en` low only masks `ir_req`; the FSM stays in PENDING.
- **Reset.** Applied at any time, including mid-PENDING or mid-SERVICE, it clears everything immediately. After reset:
  - state = IDLE.
  - `sync1`, `sync2`, `lvl`, `lvl_q` = 0; debounce counter = 0.
  - `ir_req`, `ir_pending`, `ir_in_service` = 0; `ir_lost_cnt` = 0.
- **Line held high through reset release.** Produces one `rise` once the line propagates, and so one request.

## Timing
- Take `btn_in` high and stable before clock edge k.
  - Without debounce: `lvl` rises after edge k+1; `ir_pending` rises after edge k+2.
  - With debounce: `ir_pending` rises after edge k+2+DEBOUNCE_CYCLES.
- `ir_req` follows `ir_en` combinationally while in PENDING.
- `ir_ack` sampled at edge n: `ir_req`/`ir_pending` are low and `ir_in_service` is high after edge n.
- `eret` sampled at edge n: `ir_in_service` is low after edge n.
- `ir_lost_cnt` updates at the same edge where the dropped `rise` is seen.

## Configuration
- **Macro `IR_DEBOUNCE_EN` defined.**
  - A counter clears whenever `sync2 == lvl`, and increments otherwise.
  - When it reaches DEBOUNCE_CYCLES−1 with `sync2 != lvl`, `lvl <= sync2` and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are invisible.
- **Macro not defined.**
  - `lvl <= sync2` every cycle.
  - No counter is instantiated; `DEBOUNCE_CYCLES` and `CNT_W` are unused.

## Structure
- FSM state encodings (`IR_IDLE`, `IR_PENDING`, `IR_SERVICE`, 2 bits) go in the shared `define.vh`, next to the CP0 operation codes.
- One sub-module, `ir_debounce`:
  - Contains the synchronizer, plus the counter under `IR_DEBOUNCE_EN`.
  - Inputs `clk`, `rst`, `btn_in`; output `lvl`.
  - The FSM, edge detect and lost counter stay in `ir_controller`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, LOST_W=8, `IR_DEBOUNCE_EN` defined unless noted.
- **Basic request.** Raise `btn_in` before edge 10 with `ir_en`=1 → `ir_req`=1 after edge 16. Pulse `ir_ack` at edge 20 → `ir_req`=0 and `ir_in_service`=1 after edge 20. Pulse `eret` at edge 30 → IDLE.
- **Glitch rejection.** 3-cycle `btn_in` pulse → `ir_pending` never asserts, `ir_lost_cnt`=0. Same pulse with the macro undefined → `ir_pending`=1 after edge k+2.
- **Masking.** Request arrives with `ir_en`=0 → `ir_pending`=1 and `ir_req`=0. Raise `ir_en` → `ir_req`=1 in the same cycle.
- **Lost-event saturation.** 300 clean presses while in SERVICE → `ir_lost_cnt`=255, state stays SERVICE.
- **Simultaneous events.** `rise` coincident with `eret` → PENDING, `ir_lost_cnt` unchanged. `rise` coincident with `ir_ack` → SERVICE, `ir_lost_cnt`=1.
- **Reset mid-operation.** Assert `rst` mid-cycle while in SERVICE with `ir_lost_cnt`=5 → all outputs 0 immediately, without waiting for a clock edge. `btn_in` held high through release → exactly one new request.
